// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and rise-to-rise period of an asynchronous
// PWM input, in clk cycles, and reports a steady 0%/100% level after TIMEOUT
// cycles without a qualifying edge.
// Optional macro PWM_CAPTURE_FILTER_EN adds a FILT_LEN-sample glitch filter
// after the synchronizer. When the macro is undefined, the synchronized sample
// drives the edge detector directly.
module pwm_capture #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned TIMEOUT  = 65535,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             locked,
    output logic             level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state;
    logic             s1;
    logic             s2;
    logic             lvl;
    logic             prev;
    logic             rise_c;
    logic             fall_c;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] hi_lat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Two-flop synchronizer for the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic [3:0] run;

    // Glitch filter: lvl follows s2 only after FILT_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 4'd0;
            lvl <= 1'b0;
        end else if (s2 == lvl) begin
            run <= 4'd0;
        end else if (run == 4'(FILT_LEN - 1)) begin
            run <= 4'd0;
            lvl <= s2;
        end else begin
            run <= run + 4'd1;
        end
    end
`else
    logic [3:0] unused_filt_len;

    // Filter length only shapes the filtered build
    always_comb unused_filt_len = 4'(FILT_LEN);

    // Unfiltered build: the synchronized sample is the level
    always_comb lvl = s2;
`endif

    // Previous level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= lvl;
        end
    end

    // Edge detect on the synchronized level
    always_comb begin
        rise_c = lvl & ~prev;
        fall_c = ~lvl & prev;
    end

    assign level = lvl;

    // Measurement state machine with counters and registered report outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            per_cnt   <= '0;
            hi_cnt    <= '0;
            idle_cnt  <= '0;
            hi_lat    <= '0;
            high_time <= '0;
            period    <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
        end else begin
            valid   <= 1'b0;
            per_cnt <= sat_inc(per_cnt);
            if (state == HIGH) begin
                hi_cnt <= sat_inc(hi_cnt);
            end
            unique case (state)
                IDLE: begin
                    idle_cnt <= sat_inc(idle_cnt);
                    if (rise_c) begin
                        state   <= HIGH;
                        locked  <= 1'b1;
                        per_cnt <= CNT_ONE;
                        hi_cnt  <= CNT_ONE;
                    end else if (fall_c) begin
                        idle_cnt <= CNT_ONE;
                    end else if (idle_cnt == TO_VAL) begin
                        valid     <= 1'b1;
                        period    <= TO_VAL;
                        high_time <= lvl ? TO_VAL : '0;
                        idle_cnt  <= CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall_c) begin
                        hi_lat <= hi_cnt;
                        state  <= LOW;
                    end else if (per_cnt == TO_VAL) begin
                        valid     <= 1'b1;
                        period    <= TO_VAL;
                        high_time <= lvl ? TO_VAL : '0;
                        idle_cnt  <= CNT_ONE;
                        state     <= IDLE;
                        locked    <= 1'b0;
                    end
                end
                LOW: begin
                    if (rise_c) begin
                        valid     <= 1'b1;
                        high_time <= hi_lat;
                        period    <= per_cnt;
                        per_cnt   <= CNT_ONE;
                        hi_cnt    <= CNT_ONE;
                        state     <= HIGH;
                    end else if (per_cnt == TO_VAL) begin
                        valid     <= 1'b1;
                        period    <= TO_VAL;
                        high_time <= lvl ? TO_VAL : '0;
                        idle_cnt  <= CNT_ONE;
                        state     <= IDLE;
                        locked    <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed PWM stimulus for pwm_capture with a
// timestamp-based reference model feeding a scoreboard queue; a separate
// monitor compares every valid report, plus locked/level each cycle.
module tb_pwm_capture;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 50;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             locked;
    logic             level;

    pwm_capture #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .FILT_LEN (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .high_time (high_time),
        .period    (period),
        .valid     (valid),
        .locked    (locked),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ht;
        int per;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_reports = 0;

    // Reference model: each edge index k is the cycle at which the design acts
    // on the level it sees; the level is pwm_in delayed by the synchronizer.
    int k = 0;
    bit h1 = 0, h2 = 0, hp = 0;
    bit tracking = 0;
    int last_rise = 0;
    int last_evt = 0;
    int hi_len = 0;
    bit exp_locked = 0;
    bit exp_level = 0;

    always @(posedge clk) begin : model
        bit lv, rise, fall;
        k++;
        if (rst) begin
            h1 = 0; h2 = 0; hp = 0;
            tracking = 0;
            last_evt = k + 1;
            exp_locked = 0;
            exp_level = 0;
        end else begin
            lv   = h2;
            rise = lv && !hp;
            fall = !lv && hp;
            if (tracking) begin
                if (rise) begin
                    q.push_back('{hi_len, k - last_rise});
                    last_rise = k;
                end else if (fall) begin
                    hi_len = k - last_rise;
                end else if (k - last_rise == int'(TIMEOUT)) begin
                    q.push_back('{lv ? int'(TIMEOUT) : 0, int'(TIMEOUT)});
                    tracking = 0;
                    last_evt = k;
                end
            end else begin
                if (rise) begin
                    tracking = 1;
                    last_rise = k;
                end else if (fall) begin
                    last_evt = k;
                end else if (k - last_evt == int'(TIMEOUT)) begin
                    q.push_back('{lv ? int'(TIMEOUT) : 0, int'(TIMEOUT)});
                    last_evt = k;
                end
            end
            exp_locked = tracking;
            exp_level  = h1;
            hp = h2;
            h2 = h1;
            h1 = pwm_in;
        end
    end

    // Monitor: pops the scoreboard on every valid and checks status outputs
    bit prev_valid = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            n_checks++;
            if (locked !== exp_locked) begin
                n_fail++;
                $display("FAIL locked @k=%0d: got %b want %b", k, locked, exp_locked);
            end
            n_checks++;
            if (level !== exp_level) begin
                n_fail++;
                $display("FAIL level @k=%0d: got %b want %b", k, level, exp_level);
            end
            n_checks++;
            if (valid && prev_valid) begin
                n_fail++;
                $display("FAIL valid_back_to_back @k=%0d: got 1 want 0", k);
            end
            if (valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid @k=%0d: got ht=%0d per=%0d want none",
                             k, high_time, period);
                end else begin
                    e = q.pop_front();
                    n_reports++;
                    if (int'(high_time) != e.ht || int'(period) != e.per) begin
                        n_fail++;
                        $display("FAIL report @k=%0d: got ht=%0d per=%0d want ht=%0d per=%0d",
                                 k, high_time, period, e.ht, e.per);
                    end
                end
            end else if (q.size() != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_valid @k=%0d: got valid=0 want ht=%0d per=%0d",
                         k, q[0].ht, q[0].per);
                void'(q.pop_front());
            end
        end
        prev_valid = valid;
    end

    task automatic seg(input bit v, input int n);
        pwm_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulses(input int hi, input int per, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            seg(1'b1, hi);
            seg(1'b0, per - hi);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (high_time !== '0 || period !== '0 || valid !== 1'b0 ||
            locked !== 1'b0 || level !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ht=%0d per=%0d v=%b lk=%b lv=%b want all 0",
                     high_time, period, valid, locked, level);
        end
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset(5);
        // clean PWM 3/10
        pulses(3, 10, 5);
        // duty change to 7/10
        pulses(7, 10, 4);
        // 2-cycle low glitch inside a high phase splits the period
        seg(1'b1, 3); seg(1'b0, 2); seg(1'b1, 2); seg(1'b0, 3);
        pulses(7, 10, 2);
        // stuck high, then stuck low
        seg(1'b1, 130);
        seg(1'b0, 130);
        pulses(3, 10, 2);
        // rise coinciding with the timeout, then fall coinciding with it
        seg(1'b1, 20); seg(1'b0, 30);
        seg(1'b1, 50); seg(1'b0, 10);
        pulses(4, 9, 2);
        // reset during a high phase
        seg(1'b1, 2);
        do_reset(1);
        seg(1'b1, 1); seg(1'b0, 7);
        pulses(3, 10, 3);
        // minimum 1-cycle high and low phases
        pulses(1, 2, 4);
        pulses(1, 5, 2);
        pulses(4, 5, 2);
        // randomized segments
        for (int i = 0; i < 60; i++) begin
            int len;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(40, 70))
                                              : int'($urandom_range(1, 20));
            seg(i[0], len);
        end
        seg(1'b0, 60);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        n_checks++;
        if (n_reports < 30) begin
            n_fail++;
            $display("FAIL report_count: got %0d want >= 30", n_reports);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
